// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue pipes and the multiply/divide unit.
// The master drives requests and result acceptance; the slave is the execution unit.
interface muldiv_unit_if #(
   parameter int XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      in_aluop;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic            in_tag;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic            out_tag;
   logic            out_illegal;

   modport master (
      output in_valid, in_aluop, in_rs1, in_rs2, in_tag, flush, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_aluop, in_rs1, in_rs2, in_tag, flush, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_illegal
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes with a final sign fix-up.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input logic         clk,
   input logic         rst,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);

   localparam logic [4:0] OP_MUL    = 5'b10110;
   localparam logic [4:0] OP_MULH   = 5'b10010;
   localparam logic [4:0] OP_MULHSU = 5'b10001;
   localparam logic [4:0] OP_MULHU  = 5'b10000;
   localparam logic [4:0] OP_DIV    = 5'b11000;
   localparam logic [4:0] OP_DIVU   = 5'b11010;
   localparam logic [4:0] OP_REM    = 5'b11100;
   localparam logic [4:0] OP_REMU   = 5'b11110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [4:0] op);
      case (op)
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: op_legal = 1'b1;
         default:                          op_legal = 1'b0;
      endcase
   endfunction

   function automatic logic op_is_mul(input logic [4:0] op);
      case (op)
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: op_is_mul = 1'b1;
         default:                              op_is_mul = 1'b0;
      endcase
   endfunction

   function automatic logic op_is_quot(input logic [4:0] op);
      case (op)
         OP_DIV, OP_DIVU: op_is_quot = 1'b1;
         default:         op_is_quot = 1'b0;
      endcase
   endfunction

   function automatic logic op_is_srem(input logic [4:0] op);
      case (op)
         OP_REM:  op_is_srem = 1'b1;
         default: op_is_srem = 1'b0;
      endcase
   endfunction

   function automatic logic op_a_signed(input logic [4:0] op);
      case (op)
         OP_MULH, OP_MULHSU, OP_DIV, OP_REM: op_a_signed = 1'b1;
         default:                            op_a_signed = 1'b0;
      endcase
   endfunction

   function automatic logic op_b_signed(input logic [4:0] op);
      case (op)
         OP_MULH, OP_DIV, OP_REM: op_b_signed = 1'b1;
         default:                 op_b_signed = 1'b0;
      endcase
   endfunction

   state_t            state_r, state_next_s;
   logic [CW-1:0]     cnt_r;
   logic [4:0]        op_r;
   logic [XLEN-1:0]   opnd_r;
   logic [2*XLEN-1:0] acc_r;
   logic              neg_r;
   logic [XLEN-1:0]   result_r;
   logic              tag_r;
   logic              illegal_r;
   logic              ready_r;
   logic              valid_r;

   logic              accept_s, legal_s, divz_s, ovf_s, fast_s;
   logic [XLEN-1:0]   fast_result_s;
   logic              a_neg_s, b_neg_s, init_neg_s;
   logic [XLEN-1:0]   mag_a_s, mag_b_s, init_opnd_s;
   logic [2*XLEN-1:0] init_acc_s;
   logic [XLEN:0]     mul_sum_s;
   logic [XLEN:0]     div_trial_s;
   logic              div_ge_s;
   logic [XLEN-1:0]   div_diff_s;
   logic [2*XLEN-1:0] step_acc_s, prod_s;
   logic [XLEN-1:0]   divval_s, sdiv_s, fixup_result_s;
   logic              ready_next_s, valid_next_s;

   assign bus.in_ready    = ready_r;
   assign bus.out_valid   = valid_r;
   assign bus.out_result  = result_r;
   assign bus.out_tag     = tag_r;
   assign bus.out_illegal = illegal_r;

   // State register with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         ready_r <= 1'b1;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         ready_r <= ready_next_s;
         valid_r <= valid_next_s;
      end
   end

   // Next-state logic; flush wins over both handshakes.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.flush)         state_next_s = IDLE;
            else if (bus.in_valid) state_next_s = fast_s ? DONE : BUSY;
            else                   state_next_s = IDLE;
         end
         BUSY: begin
            if (bus.flush)             state_next_s = IDLE;
            else if (cnt_r == CNT_ONE) state_next_s = DONE;
            else                       state_next_s = BUSY;
         end
         DONE: begin
            if (bus.flush)                       state_next_s = IDLE;
            else if (valid_r && bus.out_ready)   state_next_s = IDLE;
            else                                 state_next_s = DONE;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Output and datapath combinational logic.
   always_comb begin
      accept_s    = (state_r == IDLE) && bus.in_valid && !bus.flush;
      legal_s     = op_legal(bus.in_aluop);
      divz_s      = legal_s && !op_is_mul(bus.in_aluop) && (bus.in_rs2 == {XLEN{1'b0}});
      ovf_s       = legal_s && !op_is_mul(bus.in_aluop) && op_b_signed(bus.in_aluop)
                    && (bus.in_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                    && (bus.in_rs2 == {XLEN{1'b1}});
      fast_s      = !legal_s || divz_s || ovf_s;

      fast_result_s = {XLEN{1'b0}};
      if (!legal_s)    fast_result_s = {XLEN{1'b0}};
      else if (divz_s) fast_result_s = op_is_quot(bus.in_aluop) ? {XLEN{1'b1}} : bus.in_rs1;
      else if (ovf_s)  fast_result_s = op_is_quot(bus.in_aluop) ? bus.in_rs1 : {XLEN{1'b0}};
      else             fast_result_s = {XLEN{1'b0}};

      a_neg_s     = op_a_signed(bus.in_aluop) && bus.in_rs1[XLEN-1];
      b_neg_s     = op_b_signed(bus.in_aluop) && bus.in_rs2[XLEN-1];
      mag_a_s     = a_neg_s ? -bus.in_rs1 : bus.in_rs1;
      mag_b_s     = b_neg_s ? -bus.in_rs2 : bus.in_rs2;
      init_neg_s  = op_is_srem(bus.in_aluop) ? a_neg_s : (a_neg_s ^ b_neg_s);
      // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
      init_opnd_s = op_is_mul(bus.in_aluop) ? mag_a_s : mag_b_s;
      init_acc_s  = {{XLEN{1'b0}}, op_is_mul(bus.in_aluop) ? mag_b_s : mag_a_s};

      mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]}
                    + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
      div_trial_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
      div_ge_s    = div_trial_s >= {1'b0, opnd_r};
      div_diff_s  = div_trial_s[XLEN-1:0] - opnd_r;

      step_acc_s = {2*XLEN{1'b0}};
      if (op_is_mul(op_r)) begin
         step_acc_s = {mul_sum_s, acc_r[XLEN-1:1]};
      end else begin
         step_acc_s = {(div_ge_s ? div_diff_s : div_trial_s[XLEN-1:0]),
                       acc_r[XLEN-2:0], div_ge_s};
      end

      prod_s   = neg_r ? -step_acc_s : step_acc_s;
      divval_s = op_is_quot(op_r) ? step_acc_s[XLEN-1:0] : step_acc_s[2*XLEN-1:XLEN];
      sdiv_s   = neg_r ? -divval_s : divval_s;
      fixup_result_s = {XLEN{1'b0}};
      if (!op_is_mul(op_r))     fixup_result_s = sdiv_s;
      else if (op_r == OP_MUL)  fixup_result_s = prod_s[XLEN-1:0];
      else                      fixup_result_s = prod_s[2*XLEN-1:XLEN];

      ready_next_s = (state_next_s == IDLE);
      // out_valid trails entry into DONE by one edge, so outputs are settled before it rises.
      valid_next_s = (state_r == DONE) && (state_next_s == DONE);
   end

   // Operand capture, iteration and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= CNT_ZERO;
         op_r      <= 5'b00000;
         opnd_r    <= {XLEN{1'b0}};
         acc_r     <= {2*XLEN{1'b0}};
         neg_r     <= 1'b0;
         result_r  <= {XLEN{1'b0}};
         tag_r     <= 1'b0;
         illegal_r <= 1'b0;
      end else if (accept_s) begin
         op_r      <= bus.in_aluop;
         opnd_r    <= init_opnd_s;
         acc_r     <= init_acc_s;
         neg_r     <= init_neg_s;
         tag_r     <= bus.in_tag;
         illegal_r <= !legal_s;
         cnt_r     <= fast_s ? CNT_ZERO : CNT_FULL;
         if (fast_s) begin
            result_r <= fast_result_s;
         end
      end else if (state_r == BUSY) begin
         if (bus.flush) begin
            cnt_r <= CNT_ZERO;
         end else begin
            acc_r <= step_acc_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
               result_r <= fixup_result_s;
            end
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case
// sequences (backpressure, flush, reset) and random ops against an arithmetic model.
module tb_muldiv_unit;
   localparam int XLEN = 32;
   localparam logic [4:0] OP_MUL    = 5'b10110;
   localparam logic [4:0] OP_MULH   = 5'b10010;
   localparam logic [4:0] OP_MULHSU = 5'b10001;
   localparam logic [4:0] OP_MULHU  = 5'b10000;
   localparam logic [4:0] OP_DIV    = 5'b11000;
   localparam logic [4:0] OP_DIVU   = 5'b11010;
   localparam logic [4:0] OP_REM    = 5'b11100;
   localparam logic [4:0] OP_REMU   = 5'b11110;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   muldiv_unit_if #(.XLEN(XLEN)) bus ();
   muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        tag;
      int          hold;
      logic [31:0] res;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Reference: {illegal, result} straight from the RV32M arithmetic rules.
   function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; model = {1'b0, p[31:0]}; end
         OP_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); model = {1'b0, p[63:32]}; end
         OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; model = {1'b0, p[63:32]}; end
         OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; model = {1'b0, p[63:32]}; end
         OP_DIV:    model = {1'b0, (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b))};
         OP_DIVU:   model = {1'b0, (b == 32'd0) ? 32'hFFFF_FFFF : a / b};
         OP_REM:    model = {1'b0, (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b))};
         OP_REMU:   model = {1'b0, (b == 32'd0) ? a : a % b};
         default:   model = {1'b1, 32'd0};
      endcase
   endfunction

   function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] m;
      m = model(op, a, b);
      if (m[32]) return 1;
      if ((op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU) &&
          (b == 32'd0 || ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 33;
   endfunction

   task automatic start_op(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic tag);
      @(negedge clk);
      check({name, "_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_aluop = op;
      bus.in_rs1   = a;
      bus.in_rs2   = b;
      bus.in_tag   = tag;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_aluop = 5'($urandom);
      bus.in_rs1   = $urandom;
      bus.in_rs2   = $urandom;
      bus.in_tag   = ~tag;
   endtask

   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic tag, input int hold,
                         input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
      int lat;
      start_op(name, op, a, b, tag);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.out_valid && lat < 200);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_res"}, bus.out_result, exp_res);
      check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
      check({name, "_ill"}, 32'(bus.out_illegal), 32'(exp_ill));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         check({name, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
         check({name, "_hold_res"}, bus.out_result, exp_res);
         check({name, "_hold_tag"}, 32'(bus.out_tag), 32'(tag));
         check({name, "_hold_ill"}, 32'(bus.out_illegal), 32'(exp_ill));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({name, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
      check({name, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   // Abort a long DIV 10 cycles in, offering a MUL in the same cycle; nothing must complete.
   task automatic abort_test(input string name, input logic use_rst);
      int seen;
      start_op(name, OP_DIVU, 32'd1000, 32'd3, 1'b1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      if (use_rst) rst = 1'b1;
      else         bus.flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_aluop = OP_MUL;
      bus.in_rs1   = 32'd5;
      bus.in_rs2   = 32'd6;
      bus.in_tag   = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
      check({name, "_ready"}, 32'(bus.in_ready), 32'd1);
      if (use_rst) begin
         check({name, "_res_rst"}, bus.out_result, 32'd0);
         check({name, "_tag_rst"}, 32'(bus.out_tag), 32'd0);
         check({name, "_ill_rst"}, 32'(bus.out_illegal), 32'd0);
      end
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      check({name, "_no_valid"}, 32'(seen), 32'd0);
      run_op({name, "_mul"}, OP_MUL, 32'd3, 32'd4, 1'b1, 0, 32'd12, 1'b0, 33);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0]  ops[8];
      logic [31:0] corner[6];
      logic [4:0]  op;
      logic [31:0] a, b;
      logic [32:0] m;
      int          seen;

      ops    = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};

      vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 1'b1, 0, 32'hFFFF_FFEB, 1'b0, 33};
      vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 1'b0, 0, 32'h4000_0000, 1'b0, 33};
      vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 0, 32'hFFFF_FFFE, 1'b0, 33};
      vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 0, 32'hFFFF_FFFF, 1'b0, 33};
      vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         1'b1, 0, 32'hFFFF_FFFD, 1'b0, 33};
      vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         1'b0, 0, 32'hFFFF_FFFF, 1'b0, 33};
      vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         1'b1, 0, 32'd14,        1'b0, 33};
      vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         1'b0, 0, 32'd2,         1'b0, 33};
      vecs[8]  = '{OP_DIV,    32'd7,          32'd0,         1'b1, 0, 32'hFFFF_FFFF, 1'b0, 1};
      vecs[9]  = '{OP_REMU,   32'd7,          32'd0,         1'b0, 0, 32'd7,         1'b0, 1};
      vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 1'b0, 1};
      vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 0, 32'd0,         1'b0, 1};
      vecs[12] = '{5'b00000,  32'd5,          32'd9,         1'b1, 0, 32'd0,         1'b1, 1};
      vecs[13] = '{OP_MUL,    32'h0001_0001,  32'h0000_FFFF, 1'b1, 5, 32'hFFFF_FFFF, 1'b0, 33};
      vecs[14] = '{5'b01011,  32'd1,          32'd1,         1'b0, 5, 32'd0,         1'b1, 1};
      vecs[15] = '{OP_REM,    32'd7,          32'hFFFF_FFFE, 1'b1, 0, 32'd1,         1'b0, 33};

      bus.in_valid  = 1'b0;
      bus.in_aluop  = 5'b00000;
      bus.in_rs1    = 32'd0;
      bus.in_rs2    = 32'd0;
      bus.in_tag    = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_res", bus.out_result, 32'd0);
      check("rst_tag", 32'(bus.out_tag), 32'd0);
      check("rst_ill", 32'(bus.out_illegal), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
                vecs[i].hold, vecs[i].res, vecs[i].ill, vecs[i].lat);
      end

      abort_test("flush", 1'b0);
      abort_test("reset", 1'b1);

      // Flush a finished but unconsumed result.
      start_op("flush_done", OP_DIVU, 32'd100, 32'd7, 1'b1);
      seen = 0;
      while (!bus.out_valid && seen < 200) begin
         @(posedge clk);
         #1;
         seen++;
      end
      check("flush_done_lat", 32'(seen), 32'd33);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("flush_done_valid", 32'(bus.out_valid), 32'd0);
      check("flush_done_ready", 32'(bus.in_ready), 32'd1);

      for (int r = 0; r < 60; r++) begin
         int sel;
         sel = $urandom_range(0, 9);
         op  = (sel < 8) ? ops[sel] : 5'($urandom);
         case ($urandom_range(0, 3))
            0:       begin a = $urandom; b = $urandom; end
            1:       begin a = $urandom; b = 32'($urandom_range(0, 15)); end
            2:       begin a = corner[$urandom_range(0, 5)]; b = corner[$urandom_range(0, 5)]; end
            default: begin a = $urandom; b = {{16{1'b1}}, 16'($urandom)}; end
         endcase
         m = model(op, a, b);
         run_op($sformatf("rnd%0d", r), op, a, b, 1'($urandom), $urandom_range(0, 3),
                m[31:0], m[32], model_lat(op, a, b));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
